cond_flag_unit: RTL and testbench
=================================

Name: cond_flag_unit

Overview:
- Consumer end of the ALU status interface. Latches the ALU's N/Z/C/V outputs into an architectural NZCV flag register when an S-bit update is requested.
- Evaluates the 4-bit ARM condition field of each issued instruction against those flags, through a one-deep valid/ready output stage.
- Returns the stored C flag to the ALU carryIn for ADC/SBC/RSC.
- Sits between the ALU and the execute/writeback control that decides whether an instruction commits.

Parameters:
- BYPASS, 1, 1 = a condition accepted in the same cycle as a flag write is evaluated against the incoming ALU flags; 0 = evaluated against the registered flags.
- NV_PASS, 0, value of condPass for cond 4'b1111 (NV).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- aluN  input  1  ALU negative flag
- aluZ  input  1  ALU zero flag
- aluC  input  1  ALU carry flag
- aluV  input  1  ALU overflow flag
- flagsWrite  input  1  latch ALU flags this cycle (S bit set, instruction committed)
- flush  input  1  discard the pending output-stage entry
- condIn  input  4  condition field of the issued instruction
- condValid  input  1  condIn is valid
- condReady  output  1  unit can accept condIn this cycle
- condPass  output  1  registered evaluation result
- outValid  output  1  condPass is valid
- outReady  input  1  downstream consumes condPass
- flags  output  4  registered {N,Z,C,V}
- carryOut  output  1  registered C, to the ALU carryIn

Behaviour:
- Reset (async, immediate): flags=4'b0000, carryOut=0, outValid=0, condPass=0. Reset mid-transaction drops any pending entry. First clock edge after deassertion behaves normally.
- Flag register:
  - On a clk edge with flagsWrite=1: flags <= {aluN,aluZ,aluC,aluV}.
  - Otherwise flags hold.
  - carryOut always equals flags[1].
  - Flag update is independent of the handshake and of flush.
- Evaluation flags E:
  - E = {aluN,aluZ,aluC,aluV} when BYPASS=1 and flagsWrite=1 in the accept cycle.
  - Otherwise E = the registered flags.
- Condition table (N,Z,C,V taken from E):
  - 0000 EQ Z; 0001 NE !Z
  - 0010 CS C; 0011 CC !C
  - 0100 MI N; 0101 PL !N
  - 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z
  - 1010 GE N==V; 1011 LT N!=V
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V)
  - 1110 AL 1; 1111 NV = NV_PASS
- Handshake (output state machine, states EMPTY / FULL; FULL ⇔ outValid=1):
  - condReady = !outValid | outReady (combinational; pass-through ready).
  - Accept occurs when condValid & condReady. On accept, next edge: outValid=1 and condPass=eval(condIn,E). This is one-cycle latency.
  - FULL & outReady & no accept → EMPTY.
  - FULL & outReady & accept → stays FULL with the new result (back-to-back, one per cycle).
  - FULL & !outReady → hold condPass and outValid; condReady=0; condIn is ignored.
  - condPass holds its last value while EMPTY.
- flush: at the next edge, outValid <= 0.
  - flush overrides a same-cycle accept: that entry is dropped, and the producer must treat it as consumed.
  - condReady is unaffected by flush.
- condValid=0 → no state change in the output stage, except outReady draining FULL.
- No X propagation: all outputs are driven from reset registers.

Test Plan:
- Reset: assert reset mid-FULL with flags=1111 → flags=0000, outValid=0 and carryOut=0 immediately, before the next clk edge.
- Flag latch + carry return: aluN..V=1,0,1,0 with flagsWrite=1 for one cycle, then aluC=0 with flagsWrite=0 → flags=4'b1010 and carryOut=1 from the edge onward and held.
- Full table sweep: for each of the 16 flag values, issue all 16 cond codes with outReady=1 → condPass matches the table. NV gives 0 (and 1 with NV_PASS=1). Throughput is 1/cycle, and outValid stays high across the stream.
- Bypass: flags=0000, then the same cycle flagsWrite=1 with aluZ=1 and condIn=EQ → condPass=1 with BYPASS=1, and condPass=0 with BYPASS=0.
- Backpressure: outValid=1 and outReady=0 for 3 cycles while condValid toggles → condReady=0 and condPass is stable. Release outReady with condValid=1 → the new result appears the next cycle, with no loss or duplication.
- Flush: accept GE while flush=1 → outValid=0 next cycle. Flush while FULL & !outReady → outValid=0, and condReady=1 the next cycle.

Source files
------------

// File: rtl/cond_flag_unit.sv
// Condition-flag unit: architectural NZCV register, ARM condition evaluation
// behind a one-deep valid/ready output stage, and carry return to the ALU.
module cond_flag_unit #(
  parameter bit BYPASS  = 1'b1,
  parameter bit NV_PASS = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       aluN,
  input  logic       aluZ,
  input  logic       aluC,
  input  logic       aluV,
  input  logic       flagsWrite,
  input  logic       flush,
  input  logic [3:0] condIn,
  input  logic       condValid,
  output logic       condReady,
  output logic       condPass,
  output logic       outValid,
  input  logic       outReady,
  output logic [3:0] flags,
  output logic       carryOut
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t     state_p0;
  state_t     state_nxt;
  logic [3:0] flags_p0;
  logic       pass_p0;
  logic [3:0] alu_flags;
  logic [3:0] eval_flags;
  logic       accept;

  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    logic r;
    {n, z, c, v} = f;
    case (cond)
      4'b0000: r = z;
      4'b0001: r = !z;
      4'b0010: r = c;
      4'b0011: r = !c;
      4'b0100: r = n;
      4'b0101: r = !n;
      4'b0110: r = v;
      4'b0111: r = !v;
      4'b1000: r = c & !z;
      4'b1001: r = !c | z;
      4'b1010: r = (n == v);
      4'b1011: r = (n != v);
      4'b1100: r = !z & (n == v);
      4'b1101: r = z | (n != v);
      4'b1110: r = 1'b1;
      default: r = NV_PASS;
    endcase
    return r;
  endfunction

  assign alu_flags  = {aluN, aluZ, aluC, aluV};
  // Forwarding lets a flag-setting instruction's successor see its flags in the same cycle.
  assign eval_flags = (BYPASS && flagsWrite) ? alu_flags : flags_p0;
  assign accept     = condValid & condReady;

  // Stage p0: architectural flag register, independent of the handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_p0 <= 4'b0000;
    end else if (flagsWrite) begin
      flags_p0 <= alu_flags;
    end
  end

  // Stage p0: output-stage state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p0 <= EMPTY;
    end else begin
      state_p0 <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pass_p0 <= 1'b0;
    end else if (accept && !flush) begin
      pass_p0 <= cond_eval(condIn, eval_flags);
    end
  end

  always_comb begin
    state_nxt = state_p0;
    if (flush) begin
      state_nxt = EMPTY;
    end else if (accept) begin
      state_nxt = FULL;
    end else if (state_p0 == FULL && outReady) begin
      state_nxt = EMPTY;
    end
  end

  always_comb begin
    outValid  = (state_p0 == FULL);
    condReady = !outValid | outReady;
    condPass  = pass_p0;
    flags     = flags_p0;
    carryOut  = flags_p0[1];
  end

endmodule

// File: tb/tb_cond_flag_unit.sv
// Scoreboard bench for cond_flag_unit: two instances (bypass/NV=0 and
// registered/NV=1) share stimulus; a monitor checks every consumed result.
module tb_cond_flag_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       aluN, aluZ, aluC, aluV;
  logic       flagsWrite, flush, condValid, outReady;
  logic [3:0] condIn;

  logic       condReady0, condPass0, outValid0, carryOut0;
  logic [3:0] flags0;
  logic       condReady1, condPass1, outValid1, carryOut1;
  logic [3:0] flags1;

  int compared = 0;
  int mismatched = 0;

  logic q0[$];
  logic q1[$];
  logic [3:0] m_flags;
  logic       m_full;

  always #5 clk = ~clk;

  cond_flag_unit #(.BYPASS(1'b1), .NV_PASS(1'b0)) dut0 (
    .clk(clk), .reset(reset), .aluN(aluN), .aluZ(aluZ), .aluC(aluC), .aluV(aluV),
    .flagsWrite(flagsWrite), .flush(flush), .condIn(condIn), .condValid(condValid),
    .condReady(condReady0), .condPass(condPass0), .outValid(outValid0),
    .outReady(outReady), .flags(flags0), .carryOut(carryOut0)
  );

  cond_flag_unit #(.BYPASS(1'b0), .NV_PASS(1'b1)) dut1 (
    .clk(clk), .reset(reset), .aluN(aluN), .aluZ(aluZ), .aluC(aluC), .aluV(aluV),
    .flagsWrite(flagsWrite), .flush(flush), .condIn(condIn), .condValid(condValid),
    .condReady(condReady1), .condPass(condPass1), .outValid(outValid1),
    .outReady(outReady), .flags(flags1), .carryOut(carryOut1)
  );

  function automatic void check(input string nm, input logic [3:0] act, input logic [3:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endfunction

  // Paired form: odd codes are the complement of the even code below them.
  function automatic logic model(input logic [3:0] cd, input logic [3:0] f, input logic nvp);
    logic n, z, c, v, b;
    {n, z, c, v} = f;
    if (cd == 4'b1110) return 1'b1;
    if (cd == 4'b1111) return nvp;
    case (cd[3:1])
      3'd0: b = z;
      3'd1: b = c;
      3'd2: b = n;
      3'd3: b = v;
      3'd4: b = c && !z;
      3'd5: b = (n ~^ v);
      default: b = !z && (n ~^ v);
    endcase
    return cd[0] ? !b : b;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (outValid0 && outReady) begin
        if (q0.size() == 0) check("dut0_unexpected_output", 4'd1, 4'd0);
        else check("dut0_condPass", {3'b0, condPass0}, {3'b0, q0.pop_front()});
      end
      if (outValid1 && outReady) begin
        if (q1.size() == 0) check("dut1_unexpected_output", 4'd1, 4'd0);
        else check("dut1_condPass", {3'b0, condPass1}, {3'b0, q1.pop_front()});
      end
    end
  end

  // One cycle: drive inputs just after an edge, predict, then advance to just after the next edge.
  task automatic drive(input logic cv, input logic [3:0] cd, input logic fw,
                       input logic [3:0] alu, input logic ordy, input logic fl);
    logic acc, old_full;
    condValid = cv; condIn = cd; flagsWrite = fw; outReady = ordy; flush = fl;
    {aluN, aluZ, aluC, aluV} = alu;
    acc = cv && (!m_full || ordy);
    old_full = m_full;
    if (acc && !fl) begin
      q0.push_back(model(cd, fw ? alu : m_flags, 1'b0));
      q1.push_back(model(cd, m_flags, 1'b1));
    end
    #1;
    check("condReady0", {3'b0, condReady0}, {3'b0, !m_full || ordy});
    check("condReady1", {3'b0, condReady1}, {3'b0, !m_full || ordy});
    @(posedge clk);
    if (fw) m_flags = alu;
    if (fl && !acc && old_full && !ordy) begin
      void'(q0.pop_back());
      void'(q1.pop_back());
    end
    m_full = fl ? 1'b0 : acc ? 1'b1 : (m_full && ordy) ? 1'b0 : m_full;
    #1;
  endtask

  initial begin
    logic held;
    reset = 1'b1;
    {aluN, aluZ, aluC, aluV} = 4'b0;
    flagsWrite = 0; flush = 0; condValid = 0; outReady = 0; condIn = 4'b0;
    m_flags = 4'b0; m_full = 1'b0;
    #2;
    check("reset_flags", flags0, 4'b0000);
    check("reset_outValid", {3'b0, outValid0}, 4'd0);
    check("reset_condPass", {3'b0, condPass0}, 4'd0);
    check("reset_carryOut", {3'b0, carryOut0}, 4'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // Flag latch and carry return
    drive(1'b0, 4'h0, 1'b1, 4'b1010, 1'b1, 1'b0);
    check("latch_flags", flags0, 4'b1010);
    check("latch_carry", {3'b0, carryOut0}, 4'd1);
    drive(1'b0, 4'h0, 1'b0, 4'b1000, 1'b1, 1'b0);
    check("hold_flags", flags1, 4'b1010);
    check("hold_carry", {3'b0, carryOut1}, 4'd1);

    // Full table sweep, one condition per cycle
    for (int f = 0; f < 16; f++) begin
      drive(1'b0, 4'h0, 1'b1, 4'(f), 1'b1, 1'b0);
      for (int c = 0; c < 16; c++) begin
        drive(1'b1, 4'(c), 1'b0, 4'b0000, 1'b1, 1'b0);
        check("stream_outValid", {3'b0, outValid0}, 4'd1);
      end
    end
    drive(1'b0, 4'h0, 1'b1, 4'b0000, 1'b1, 1'b0);

    // Bypass: EQ sees incoming Z=1 only on the bypass instance
    drive(1'b1, 4'b0000, 1'b1, 4'b0100, 1'b1, 1'b0);
    check("bypass_on", {3'b0, condPass0}, 4'd1);
    check("bypass_off", {3'b0, condPass1}, 4'd0);
    drive(1'b0, 4'h0, 1'b1, 4'b1000, 1'b1, 1'b0);

    // Backpressure: GE with N=1,V=0 is 0; AL afterwards is 1
    drive(1'b1, 4'b1010, 1'b0, 4'b0000, 1'b1, 1'b0);
    held = condPass0;
    check("bp_first", {3'b0, held}, 4'd0);
    for (int i = 0; i < 3; i++) begin
      drive((i % 2) == 0, 4'b1110, 1'b0, 4'b0000, 1'b0, 1'b0);
      check("bp_outValid", {3'b0, outValid0}, 4'd1);
      check("bp_stable", {3'b0, condPass0}, {3'b0, held});
    end
    drive(1'b1, 4'b1110, 1'b0, 4'b0000, 1'b1, 1'b0);
    check("bp_release_valid", {3'b0, outValid0}, 4'd1);
    check("bp_release_pass", {3'b0, condPass0}, 4'd1);
    drive(1'b0, 4'h0, 1'b0, 4'b0000, 1'b1, 1'b0);
    check("bp_drained", {3'b0, outValid0}, 4'd0);

    // Flush: accept dropped, then pending entry dropped under backpressure
    drive(1'b1, 4'b1010, 1'b0, 4'b0000, 1'b1, 1'b1);
    check("flush_accept", {3'b0, outValid0}, 4'd0);
    drive(1'b1, 4'b1011, 1'b0, 4'b0000, 1'b0, 1'b0);
    check("fill_before_flush", {3'b0, outValid0}, 4'd1);
    drive(1'b0, 4'h0, 1'b0, 4'b0000, 1'b0, 1'b1);
    check("flush_full", {3'b0, outValid1}, 4'd0);
    check("flush_ready", {3'b0, condReady0}, 4'd1);

    // Asynchronous reset while FULL with flags 1111
    drive(1'b1, 4'b1110, 1'b1, 4'b1111, 1'b0, 1'b0);
    check("pre_reset_flags", flags0, 4'b1111);
    reset = 1'b1;
    #1;
    check("async_flags", flags0, 4'b0000);
    check("async_carry", {3'b0, carryOut0}, 4'd0);
    check("async_outValid", {3'b0, outValid0}, 4'd0);
    q0.delete(); q1.delete();
    m_flags = 4'b0; m_full = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    drive(1'b1, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0);
    check("post_reset_pass", {3'b0, condPass0}, 4'd1);
    drive(1'b0, 4'h0, 1'b0, 4'b0000, 1'b1, 1'b0);
    drive(1'b0, 4'h0, 1'b0, 4'b0000, 1'b1, 1'b0);
    check("queue0_empty", 4'(q0.size()), 4'd0);
    check("queue1_empty", 4'(q1.size()), 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
